// File: rtl/tty_mmio_port.sv
// tty_mmio_port
// Memory-mapped bridge between the MIPS data bus and a TTY character device.
// The receive side captures TTY characters into an RX FIFO. The transmit side
// drains a TX FIFO to the TTY through the DSR/DTR strobe handshake.
//
// Ports:
//   clk, rst_n        system clock, synchronous active-low reset
//   cs, we, addr      bus request (addr 0 DATA, 1 STATUS, 2 CTRL, 3 reserved)
//   wdata, rdata      bus write data; registered read data
//   irq               level interrupt, registered
//   tty_td, tty_rts   character and "character present" strobe from the TTY
//   tty_cts           controller can accept a character
//   tty_rd, tty_dsr   character to the TTY and its one-cycle valid strobe
//   tty_dtr           TTY ready to accept a character
//
// Optional feature: define TTY_MMIO_ECHO_EN to add CTRL bit4 (echo_en), which
// copies every stored RX character into the TX FIFO.
//
// Handshake semantics: tty_rts/tty_dtr are asynchronous levels and are only
// used after SYNC_STAGES flops. A rising edge of synchronised RTS means
// "tty_td holds a new character" and it is sampled in that cycle. A character
// is sent only while synchronised DTR is high; tty_rd is driven for SETUP_CYC
// cycles before tty_dsr pulses for one cycle, then held one more cycle.
// The TX FSM state is visible as tx_state for checkers.

module tty_mmio_port #(
    parameter int DATA_W      = 8,
    parameter int RX_DEPTH    = 4,
    parameter int TX_DEPTH    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int SETUP_CYC   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              we,
    input  logic [1:0]        addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              irq,
    input  logic [DATA_W-1:0] tty_td,
    input  logic              tty_rts,
    output logic              tty_cts,
    output logic [DATA_W-1:0] tty_rd,
    output logic              tty_dsr,
    input  logic              tty_dtr
);

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int SET_W = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
`ifdef TTY_MMIO_ECHO_EN
    localparam int CTRL_W = 5;
`else
    localparam int CTRL_W = 4;
`endif

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} tx_state_t;
    tx_state_t tx_state;

    logic [CTRL_W-1:0]      ctrl;
    logic [SYNC_STAGES-1:0] rts_sync;
    logic [SYNC_STAGES-1:0] dtr_sync;
    logic                   rts_prev;
    logic                   rx_ovr;
    logic                   tx_drop;
    logic [SET_W-1:0]       setup_cnt;

    logic [DATA_W-1:0] rx_mem [RX_DEPTH];
    logic [RX_AW-1:0]  rx_wptr, rx_rptr;
    logic [RX_AW:0]    rx_count;
    logic [DATA_W-1:0] tx_mem [TX_DEPTH];
    logic [TX_AW-1:0]  tx_wptr, tx_rptr;
    logic [TX_AW:0]    tx_count;

    logic rx_en, tx_en, irq_rx_en, irq_tx_en;
    logic rts_edge, dtr_s;
    logic rx_valid, rx_full, tx_full, tx_empty, tx_busy;
    logic rd_cyc, data_rd, data_wr, stat_wr, ctrl_wr;
    logic rx_pop, rx_try, rx_push, rx_ovr_set;
    logic tx_push, tx_pop, tx_drop_set;
    logic [DATA_W-1:0] tx_push_data;
    logic [31:0] status, rd_mux;
    logic unused_wdata;

    assign rx_en     = ctrl[0];
    assign tx_en     = ctrl[1];
    assign irq_rx_en = ctrl[2];
    assign irq_tx_en = ctrl[3];

    assign rts_edge = rts_sync[SYNC_STAGES-1] && !rts_prev;
    assign dtr_s    = dtr_sync[SYNC_STAGES-1];

    assign rx_valid = (rx_count != '0);
    assign rx_full  = (rx_count == (RX_AW+1)'(RX_DEPTH));
    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == (TX_AW+1)'(TX_DEPTH));
    assign tx_busy  = (tx_state != IDLE);

    assign rd_cyc  = cs && !we;
    assign data_rd = rd_cyc && (addr == 2'd0);
    assign data_wr = cs && we && (addr == 2'd0);
    assign stat_wr = cs && we && (addr == 2'd1);
    assign ctrl_wr = cs && we && (addr == 2'd2);

    // A pop in the same cycle as a capture frees the slot the capture needs.
    assign rx_pop     = data_rd && rx_valid;
    assign rx_try     = rts_edge && rx_en;
    assign rx_push    = rx_try && (!rx_full || rx_pop);
    assign rx_ovr_set = rx_try && !rx_push;

    assign tx_pop = (tx_state == IDLE) && tx_en && !tx_empty && dtr_s;

`ifdef TTY_MMIO_ECHO_EN
    logic echo_try;
    // The bus write owns the TX push port; a colliding echo is lost.
    assign echo_try     = ctrl[4] && rx_push;
    assign tx_push      = (data_wr || echo_try) && !tx_full;
    assign tx_push_data = data_wr ? wdata[DATA_W-1:0] : tty_td;
    assign tx_drop_set  = (data_wr && tx_full) || (echo_try && (data_wr || tx_full));
`else
    assign tx_push      = data_wr && !tx_full;
    assign tx_push_data = wdata[DATA_W-1:0];
    assign tx_drop_set  = data_wr && tx_full;
`endif

    assign unused_wdata = ^wdata;

    always_comb begin
        status       = '0;
        status[0]    = rx_valid;
        status[1]    = rx_full;
        status[2]    = tx_full;
        status[3]    = tx_empty;
        status[4]    = tx_busy;
        status[5]    = rx_ovr;
        status[6]    = tx_drop;
        status[15:8] = 8'(rx_count);
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            2'd0:    rd_mux = rx_valid ? 32'(rx_mem[rx_rptr]) : 32'd0;
            2'd1:    rd_mux = status;
            2'd2:    rd_mux = 32'(ctrl);
            default: rd_mux = '0;
        endcase
    end

    // Bus registers, synchronisers, flags and interrupt.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl     <= '0;
            rdata    <= '0;
            irq      <= 1'b0;
            tty_cts  <= 1'b0;
            rts_sync <= '0;
            dtr_sync <= '0;
            rts_prev <= 1'b0;
            rx_ovr   <= 1'b0;
            tx_drop  <= 1'b0;
        end else begin
            rts_sync <= {rts_sync[SYNC_STAGES-2:0], tty_rts};
            dtr_sync <= {dtr_sync[SYNC_STAGES-2:0], tty_dtr};
            rts_prev <= rts_sync[SYNC_STAGES-1];
            if (rd_cyc)
                rdata <= rd_mux;
            if (ctrl_wr)
                ctrl <= wdata[CTRL_W-1:0];
            // A new event in the same cycle as a clear wins.
            if (rx_ovr_set)
                rx_ovr <= 1'b1;
            else if (stat_wr && wdata[5])
                rx_ovr <= 1'b0;
            if (tx_drop_set)
                tx_drop <= 1'b1;
            else if (stat_wr && wdata[6])
                tx_drop <= 1'b0;
            tty_cts <= rx_en && !rx_full;
            irq     <= (irq_rx_en && rx_valid) || (irq_tx_en && tx_empty && !tx_busy);
        end
    end

    // FIFO storage carries no reset; the pointers and counts define validity.
    always_ff @(posedge clk) begin
        if (rx_push)
            rx_mem[rx_wptr] <= tty_td;
        if (tx_push)
            tx_mem[tx_wptr] <= tx_push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
            if (rx_push && !rx_pop)      rx_count <= rx_count + 1'b1;
            else if (!rx_push && rx_pop) rx_count <= rx_count - 1'b1;
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
            if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
            else if (!tx_push && tx_pop) tx_count <= tx_count - 1'b1;
        end
    end

    // Transmit sequencer: load, hold tty_rd for SETUP_CYC, strobe, hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state  <= IDLE;
            setup_cnt <= '0;
            tty_rd    <= '0;
            tty_dsr   <= 1'b0;
        end else begin
            case (tx_state)
                IDLE: begin
                    if (tx_pop) begin
                        tty_rd    <= tx_mem[tx_rptr];
                        setup_cnt <= '0;
                        tx_state  <= SETUP;
                    end
                end
                SETUP: begin
                    if (setup_cnt == SET_W'(SETUP_CYC - 1)) begin
                        tty_dsr  <= 1'b1;
                        tx_state <= STROBE;
                    end else begin
                        setup_cnt <= setup_cnt + 1'b1;
                    end
                end
                STROBE: begin
                    tty_dsr  <= 1'b0;
                    tx_state <= HOLD;
                end
                HOLD: begin
                    tx_state <= IDLE;
                end
                default: begin
                    tty_dsr  <= 1'b0;
                    tx_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/tty_mmio_port.md
Name: tty_mmio_port

Overview:
- Memory-mapped controller between the MIPS data bus (chip-select, word addressed) and the TTY device handshake pins (TD/RD/RTS/CTS/DSR/DTR).
- Receive side: captures TTY characters into an RX FIFO. Transmit side: drains a TX FIFO to the TTY through the DSR/DTR handshake.
- Replaces the delayed-RTS register-clock scheme with synchronised edge detection, parametrised width and depth, status/control registers and an interrupt.

Parameters:
- DATA_W, 8, character width (TD/RD width).
- RX_DEPTH, 4, RX FIFO entries; power of two, at least 2.
- TX_DEPTH, 4, TX FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2, flip-flop stages on RTS and DTR; at least 2.
- SETUP_CYC, 2, cycles RD is held stable before DSR asserts; at least 1.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- cs  in  1  chip select from the address decoder.
- we  in  1  1 = write, 0 = read; qualified by cs.
- addr  in  2  register select: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved.
- wdata  in  32  write data.
- rdata  out  32  read data, registered.
- irq  out  1  level interrupt.
- tty_td  in  DATA_W  character from the TTY.
- tty_rts  in  1  TTY has a character on TD (asynchronous).
- tty_cts  out  1  controller can accept a character.
- tty_rd  out  DATA_W  character to the TTY.
- tty_dsr  out  1  strobe: tty_rd is valid.
- tty_dtr  in  1  TTY ready to accept (asynchronous).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FIFOs empty; FSM in IDLE; CTRL = 0.
  - rdata=0, irq=0, tty_cts=0, tty_rd=0, tty_dsr=0.
  - Sticky flags cleared; synchroniser flops cleared.
  - Reset mid-transfer aborts immediately. A TX character in flight is lost.
- CTRL (addr 2, R/W):
  - bit0 rx_en, bit1 tx_en, bit2 irq_rx_en, bit3 irq_tx_en.
  - Other bits read 0.
- STATUS (addr 1):
  - bit0 rx_valid, bit1 rx_full, bit2 tx_full, bit3 tx_empty, bit4 tx_busy (FSM not IDLE), bit5 rx_ovr, bit6 tx_drop.
  - bits[15:8] rx_count.
  - Write: a 1 in bit5 or bit6 clears that sticky flag; other bits are ignored.
- DATA (addr 0):
  - Read returns the RX head zero-extended in rdata and pops it in the request cycle.
  - Read when empty returns 0, no pop.
  - Write pushes wdata[DATA_W-1:0] to the TX FIFO. If TX is full, the write is dropped and tx_drop is set.
- Read timing:
  - rdata is updated one cycle after a cs&&!we cycle; otherwise it holds its value.
  - Reserved address reads 0; writes to it are ignored.
- RX path:
  - tty_cts = rx_en && !rx_full, registered.
  - tty_rts passes through SYNC_STAGES flops. A rising edge of the synchronised signal pushes tty_td, sampled in that same cycle. Total capture latency is SYNC_STAGES+1 cycles from RTS rise.
  - Edge while RX is full and no pop that cycle: data dropped, rx_ovr set. A pop in the same cycle makes room and the push succeeds.
  - Edge while rx_en=0: ignored.
- TX FSM (DTR synchronised like RTS):
  - IDLE: if tx_en, TX not empty and dtr_s=1: load tty_rd from the head, pop, go to SETUP.
  - SETUP: count SETUP_CYC cycles with tty_rd stable, then go to STROBE.
  - STROBE: tty_dsr=1 for exactly 1 cycle, then go to HOLD.
  - HOLD: tty_dsr=0, tty_rd held 1 cycle, then go to IDLE.
  - Minimum spacing between DSR pulses: SETUP_CYC+3 cycles.
  - tty_rd keeps its last value in IDLE.
  - Clearing tx_en mid-transfer finishes the current character; no new loads.
- irq = (irq_rx_en && rx_valid) || (irq_tx_en && tx_empty && !tx_busy); registered, 1-cycle latency.
- FIFO pointers wrap modulo depth. Counts are width log2(depth)+1, so full = depth and empty = 0 are distinct.

Optional Feature:
- Macro TTY_MMIO_ECHO_EN.
- When defined, CTRL bit4 (echo_en) exists. With echo_en=1, every successfully pushed RX character is also pushed into the TX FIFO in the same cycle.
  - A bus write to DATA in the same cycle has priority; the echo is dropped and sets tx_drop.
  - The RX copy is still stored.
- When undefined, CTRL bit4 reads 0, writes to it are ignored, and no echo logic is present.

Test Plan:
- Reset, then read STATUS -> rdata=0x0000_0008 (tx_empty only); tty_cts=0, tty_dsr=0, irq=0.
- CTRL=0x5, TTY sends 0x61 (RTS rise) -> rx_count=1 after SYNC_STAGES+1 cycles; irq=1 next cycle; DATA read returns 0x61; irq drops.
- CTRL=0x1, TTY sends 5 chars 0x30..0x34 without reads (RX_DEPTH=4) -> tty_cts=0 after the 4th; 5th dropped; STATUS rx_ovr=1; reads return 0x30..0x33; write STATUS 0x20 -> rx_ovr=0.
- CTRL=0x2, tty_dtr=1, write DATA 0x41 then 0x42 -> DSR pulses of 1 cycle each, tty_rd=0x41 stable ≥SETUP_CYC cycles before the first, then 0x42; pulses ≥SETUP_CYC+3 cycles apart.
- tty_dtr=0, write DATA 5 times with TX_DEPTH=4 -> tx_full=1, tx_drop=1, no DSR; raise DTR -> exactly 4 characters sent in order.
- With TTY_MMIO_ECHO_EN, CTRL=0x13, tty_dtr=1, TTY sends 0x7A -> DATA read returns 0x7A and a DSR pulse occurs with tty_rd=0x7A.
